// File: rtl/pc_sequencer_pkg.sv
// Core-wide types shared by the PC sequencer, decode and their benches.
package pc_sequencer_pkg;

  localparam int WORD_W = 32;
  localparam int OFF_W  = 16;
  localparam int JMP_W  = 26;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_e;

  // One action per RUN cycle, chosen by next_pc.
  typedef enum logic [2:0] {
    ACT_SEQ,
    ACT_STALL,
    ACT_BRANCH,
    ACT_JUMP,
    ACT_HALT
  } pc_act_e;

endpackage

// File: rtl/pc_sequencer_next_pc.sv
// Combinational next-PC: sequential/branch/jump targets plus the RUN-cycle priority select.
module next_pc
  import pc_sequencer_pkg::*;
#(
  parameter int IMEM_DEPTH = 256
) (
  input  logic             redir_ok,
  input  word_t            pc,
  input  word_t            id_pc,
  input  logic             stall,
  input  logic             branch,
  input  logic [OFF_W-1:0] branch_off,
  input  logic             jump,
  input  logic [JMP_W-1:0] jump_tgt,
  input  logic             halt,
  output pc_act_e          act,
  output word_t            tgt
);

  localparam word_t MASK = word_t'(IMEM_DEPTH - 1);

  word_t seq_tgt, br_tgt, jmp_tgt, off_sext;

  always_comb begin
    off_sext = {{(WORD_W-OFF_W){branch_off[OFF_W-1]}}, branch_off};
    seq_tgt  = (pc + 32'd1) & MASK;
    br_tgt   = (id_pc + 32'd1 + off_sext) & MASK;
    jmp_tgt  = {id_pc[WORD_W-1:JMP_W], jump_tgt} & MASK;
  end

  // Redirects only count for a real instruction in IF/ID; they beat stall.
  always_comb begin
    act = ACT_SEQ;
    tgt = seq_tgt;
    if (redir_ok && halt) begin
      act = ACT_HALT;
      tgt = pc;
    end else if (redir_ok && jump) begin
      act = ACT_JUMP;
      tgt = jmp_tgt;
    end else if (redir_ok && branch) begin
      act = ACT_BRANCH;
      tgt = br_tgt;
    end else if (stall) begin
      act = ACT_STALL;
      tgt = pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register, IF/ID register and BOOT/RUN/HALT control feeding the fetch block.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int RESET_PC   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ins,
  input  logic             stall,
  input  logic             branch,
  input  logic [OFF_W-1:0] branch_off,
  input  logic             jump,
  input  logic [JMP_W-1:0] jump_tgt,
  input  logic             halt,
  output logic [31:0]      pc,
  output logic [31:0]      id_ins,
  output logic [31:0]      id_pc,
  output logic             id_valid,
  output logic [1:0]       state,
  output logic [31:0]      fetch_cnt
);

  seq_state_e state_q, state_d;
  word_t      pc_q, pc_d, id_ins_q, id_ins_d, id_pc_q, id_pc_d, cnt_q, cnt_d;
  logic       id_valid_q, id_valid_d;
  pc_act_e    act;
  word_t      tgt;

  next_pc #(.IMEM_DEPTH(IMEM_DEPTH)) u_next_pc (
    .redir_ok   (id_valid_q && (state_q == RUN)),
    .pc         (pc_q),
    .id_pc      (id_pc_q),
    .stall      (stall),
    .branch     (branch),
    .branch_off (branch_off),
    .jump       (jump),
    .jump_tgt   (jump_tgt),
    .halt       (halt),
    .act        (act),
    .tgt        (tgt)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_ins_d   = id_ins_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        unique case (act)
          ACT_HALT: begin
            state_d    = HALT;
            id_valid_d = 1'b0;
          end
          ACT_JUMP, ACT_BRANCH: begin
            pc_d       = tgt;
            id_valid_d = 1'b0;
          end
          ACT_STALL: ;
          default: begin
            id_ins_d   = ins;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
            pc_d       = tgt;
            if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= word_t'(RESET_PC);
      id_ins_q   <= '0;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_ins_q   <= id_ins_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc        = pc_q;
  assign id_ins    = id_ins_q;
  assign id_pc     = id_pc_q;
  assign id_valid  = id_valid_q;
  assign state     = state_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a cycle-level reference model with a fetch memory.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins;
  logic        stall, branch, jump, halt;
  logic [15:0] branch_off;
  logic [25:0] jump_tgt;
  logic [31:0] pc, id_ins, id_pc, fetch_cnt;
  logic        id_valid;
  logic [1:0]  state;

  logic [31:0] imem [256];

  int checks   = 0;
  int failures = 0;

  // Reference model of the architectural outputs.
  logic [31:0] m_pc, m_id_ins, m_id_pc, m_cnt;
  logic        m_valid;
  int          m_state;

  always #5 clk = ~clk;

  assign ins = imem[pc[7:0]];

  pc_sequencer #(.IMEM_DEPTH(256), .RESET_PC(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .stall      (stall),
    .branch     (branch),
    .branch_off (branch_off),
    .jump       (jump),
    .jump_tgt   (jump_tgt),
    .halt       (halt),
    .pc         (pc),
    .id_ins     (id_ins),
    .id_pc      (id_pc),
    .id_valid   (id_valid),
    .state      (state),
    .fetch_cnt  (fetch_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/pc"},        pc,                m_pc);
    chk({tag, "/id_valid"},  {31'd0, id_valid}, {31'd0, m_valid});
    chk({tag, "/id_pc"},     id_pc,             m_id_pc);
    chk({tag, "/id_ins"},    id_ins,            m_id_ins);
    chk({tag, "/state"},     {30'd0, state},    m_state);
    chk({tag, "/fetch_cnt"}, fetch_cnt,         m_cnt);
  endtask

  task automatic model_reset();
    m_pc = 0; m_id_ins = 0; m_id_pc = 0; m_valid = 0; m_state = 0; m_cnt = 0;
  endtask

  // Apply one cycle of inputs, advance the model, clock the DUT, compare.
  task automatic step(input logic s, input logic b, input logic [15:0] off,
                      input logic j, input logic [25:0] t, input logic h, input string tag);
    int target;
    stall = s; branch = b; branch_off = off; jump = j; jump_tgt = t; halt = h;
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (h && m_valid) begin
        m_state = 2; m_valid = 0;
      end else if (j && m_valid) begin
        m_pc = ((m_id_pc & 32'hFC00_0000) | {6'd0, t}) % 256; m_valid = 0;
      end else if (b && m_valid) begin
        target = int'(m_id_pc) + 1 + int'($signed(off));
        m_pc = target & 255; m_valid = 0;
      end else if (!s) begin
        m_id_ins = imem[m_pc[7:0]]; m_id_pc = m_pc; m_valid = 1;
        m_pc = (m_pc + 1) % 256;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 16'd0, 0, 26'd0, 0, tag);
  endtask

  initial begin
    logic [31:0] held_ins;
    logic [31:0] held_cnt;
    foreach (imem[i]) imem[i] = $urandom;
    rst = 1'b0;
    stall = 0; branch = 0; branch_off = 0; jump = 0; jump_tgt = 0; halt = 0;
    model_reset();
    #12; check_all("reset");
    @(posedge clk); #1; rst = 1'b1;

    // Boot: one idle cycle, then sequencing from PC 0.
    idle("boot");
    chk("boot_valid0", {31'd0, id_valid}, 32'd0);
    idle("first");
    chk("first_valid", {31'd0, id_valid}, 32'd1);
    chk("first_id_pc", id_pc, 32'd0);

    for (int k = 0; k < 20 && !(m_valid && m_id_pc == 5); k++) idle("seq");
    held_ins = m_id_ins; held_cnt = m_cnt;
    for (int k = 0; k < 3; k++) step(1, 0, 16'd0, 0, 26'd0, 0, "stall");
    chk("stall_pc", pc, 32'd6);
    chk("stall_id_pc", id_pc, 32'd5);
    chk("stall_ins", id_ins, held_ins);
    chk("stall_cnt", fetch_cnt, held_cnt);
    idle("resume");
    chk("resume_id_pc", id_pc, 32'd6);

    for (int k = 0; k < 20 && !(m_valid && m_id_pc == 10); k++) idle("seq");
    step(0, 1, 16'hFFFC, 0, 26'd0, 0, "branch");
    chk("br_pc", pc, 32'd7);
    chk("br_bubble", {31'd0, id_valid}, 32'd0);
    idle("br_tgt");
    chk("br_id_pc", id_pc, 32'd7);
    chk("br_valid", {31'd0, id_valid}, 32'd1);

    step(1, 1, 16'h0003, 1, 26'h40, 0, "jump_pri");
    chk("jmp_pc", pc, 32'h40);
    chk("jmp_bubble", {31'd0, id_valid}, 32'd0);

    // Wrap-around: jump near the top and run across 255.
    idle("jmp_fill");
    step(0, 0, 16'd0, 1, 26'hF8, 0, "jmp_hi");
    for (int k = 0; k < 20 && m_pc != 255; k++) idle("to_top");
    idle("wrap");
    chk("wrap_pc", pc, 32'd0);
    step(0, 0, 16'd0, 1, 26'd250, 0, "jmp_250");
    idle("fill_250");
    step(0, 1, 16'd10, 0, 26'd0, 0, "br_wrap");
    chk("br_wrap_pc", pc, 32'd5);

    for (int k = 0; k < 400; k++)
      step($urandom_range(3) == 0, $urandom_range(9) == 0, 16'($urandom),
           $urandom_range(19) == 0, 26'($urandom), 1'b0, "rand");

    for (int k = 0; k < 10 && !m_valid; k++) idle("pre_halt");
    step(0, 0, 16'd0, 0, 26'd0, 1, "halt");
    chk("halt_state", {30'd0, state}, 32'd2);
    for (int k = 0; k < 20; k++)
      step($urandom_range(1), $urandom_range(1), 16'($urandom), 1'b1, 26'($urandom),
           $urandom_range(1), "halted");

    #2 rst = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(posedge clk); #1; rst = 1'b1;
    idle("reboot");
    for (int k = 0; k < 5; k++) idle("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer and IF/ID register for the single-issue word-addressed core. It sits directly upstream of the combinational `fetch` block: it drives `pc` into it and captures the returned `ins` in the IF/ID register. It applies the redirects and stalls raised by decode, and the halt raised by decode. It hands a valid-qualified instruction/PC pair to decode.

## Interface
Parameters:
- `IMEM_DEPTH`, 256: instruction memory words; power of two; `pc` always stays below it.
- `RESET_PC`, 0: `pc` value after reset; must be below `IMEM_DEPTH`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `ins` in 32: instruction returned by `fetch` for the current `pc`, same cycle.
- `stall` in 1: decode cannot accept; hold `pc` and the IF/ID register.
- `branch` in 1: taken branch for the instruction in IF/ID.
- `branch_off` in 16: signed word offset, relative to `id_pc+1`.
- `jump` in 1: jump for the instruction in IF/ID.
- `jump_tgt` in 26: absolute word target, low bits.
- `halt` in 1: halt for the instruction in IF/ID.
- `pc` out 32: fetch address to `fetch`.
- `id_ins` out 32: IF/ID instruction.
- `id_pc` out 32: PC of `id_ins`.
- `id_valid` out 1: `id_ins` is a real instruction.
- `state` out 2: BOOT=0, RUN=1, HALT=2.
- `fetch_cnt` out 32: count of instructions delivered to decode; saturating.

## Operation
- **Reset values:** `pc`=RESET_PC, `id_ins`=0, `id_pc`=0, `id_valid`=0, `state`=BOOT, `fetch_cnt`=0. Reset asserted mid-operation discards everything immediately.
- **BOOT:** lasts exactly one cycle. `pc` holds, `id_valid` stays 0, next state is RUN.
- **RUN:** each cycle one action is chosen, in priority order `halt` > `jump` > `branch` > `stall` > sequential.
- **Redirect qualification:** `halt`, `jump` and `branch` are honoured only when `id_valid`=1 and the state is RUN. Otherwise they are ignored.
- **Sequential:** `id_ins`←`ins`, `id_pc`←`pc`, `id_valid`←1, `pc`←(`pc`+1) mod IMEM_DEPTH.
- **Stall:** `pc`, `id_ins`, `id_pc` and `id_valid` all hold.
- **Jump:** `pc`←({`id_pc`[31:26], `jump_tgt`}) mod IMEM_DEPTH, and `id_valid`←0 to squash the wrong-path fetch. A redirect wins over a simultaneous `stall`.
- **Branch:** `pc`←(`id_pc` + 1 + sign-extended `branch_off`) mod IMEM_DEPTH, and `id_valid`←0. Computed in 32 bits; the modulo is a mask with IMEM_DEPTH−1.
- **Halt:** `state`←HALT and `id_valid`←0; `pc` holds. HALT is absorbing: only reset leaves it, and all inputs are ignored while in it.
- **fetch_cnt:** increments on every edge that loads `id_valid`←1 from sequential flow. It saturates at 0xFFFFFFFF.

## Timing
- `fetch` is combinational: `ins` corresponds to the current `pc` in the same cycle.
- A sequential step moves the instruction at `pc` into `id_ins` one cycle later.
- Redirect penalty is one bubble. The redirect cycle yields `id_valid`=0, and the target instruction appears in `id_ins` one cycle after that.
- No combinational path runs from inputs to outputs; all outputs are registered.

## Structure
- **Shared package** (core-wide): state encoding BOOT/RUN/HALT, the 32-bit word type, the 16-bit offset width and the 26-bit jump width. Decode and the bench reuse these.
- **Sub-module:** one natural sub-module, `next_pc`. It is combinational and computes the sequential, branch and jump targets plus the priority select. The registers and the FSM stay in `pc_sequencer`.
- **Top-level wiring:** the top instantiates `pc_sequencer` and `fetch` side by side, with `pc` and `ins` connecting them.

## Test plan
- **Reset and boot:** hold `rst`=0, then release it, with no stalls. Required: `pc` reads 0,0,1,2,3 on successive edges, and `id_valid` first goes to 1 on the third edge with `id_pc`=0.
- **Stall:** assert `stall` for 3 cycles with `id_pc`=5. Required: `pc`=6, `id_pc`=5 and `id_ins` all hold, and `fetch_cnt` is unchanged; sequencing resumes with `id_pc`=6.
- **Branch:** `id_pc`=10, `branch`=1, `branch_off`=0xFFFC (−4). Required: next `pc`=7 and `id_valid`=0, then `id_pc`=7 with `id_valid`=1.
- **Jump with simultaneous branch and stall:** `jump`=1, `jump_tgt`=0x40, `branch`=1, `stall`=1. Required: `pc`=0x40 and `id_valid`=0.
- **Wrap-around:** run past `pc`=255 with IMEM_DEPTH=256. Required: `pc` goes 255→0. Also a branch from `id_pc`=250 with offset +10 yields `pc`=5.
- **Halt, then reset:** `halt`=1 with `id_valid`=1. Required: `state`=HALT and `pc` is frozen for 20 cycles despite `jump`; asserting `rst` returns all outputs to their reset values asynchronously.
